// File: rtl/spi_packet_receiver.sv
// SPI mode-0 slave deserializer plus frame parser: address, size/cmd, payload,
// checksum and trailer words; streams payload and reports frame status.
module spi_packet_receiver #(
  parameter logic [7:0] BLOCK_ADDR     = 8'hAB,
  parameter logic [7:0] MAX_SIZE       = 8'h40,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_ncs,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [7:0]  out_cmd,
  output logic        frame_start,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [2:0]  dbg_state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SIZE, DATA, CSUM, TRAIL, SKIP_SIZE, SKIP} state_t;

  // Handshake: out_valid is a one-clk strobe with no back-pressure; out_data is
  // meaningful only in the cycle out_valid is high.

  logic [1:0]  sck_sync, mosi_sync, ncs_sync;
  logic        sck_prev;
  logic        sck_rise;
  logic [14:0] shift;
  logic [3:0]  bit_cnt;
  logic        word_rdy;
  logic [15:0] word;

  assign sck_rise = sck_sync[1] & ~sck_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      ncs_sync  <= 2'b11;
      sck_prev  <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      word_rdy  <= 1'b0;
      word      <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      ncs_sync  <= {ncs_sync[0], spi_ncs};
      sck_prev  <= sck_sync[1];
      word_rdy  <= 1'b0;
      if (ncs_sync[1]) begin
        // Deselect drops any partial word; frame state is left untouched.
        bit_cnt <= '0;
        shift   <= '0;
      end else if (sck_rise) begin
        shift <= {shift[13:0], mosi_sync[1]};
        if (bit_cnt == 4'd15) begin
          word     <= {shift, mosi_sync[1]};
          word_rdy <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  state_t      state, state_n;
  logic [15:0] csum, csum_n;
  logic [7:0]  remain, remain_n;
  logic [7:0]  skip, skip_n;
  logic        csum_ok, csum_ok_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [15:0] data_n;
  logic [7:0]  cmd_n;
  logic [1:0]  code_n;
  logic        valid_n, start_n, ok_n, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      csum        <= '0;
      remain      <= '0;
      skip        <= '0;
      csum_ok     <= 1'b0;
      to_cnt      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_cmd     <= '0;
      frame_start <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      state       <= state_n;
      csum        <= csum_n;
      remain      <= remain_n;
      skip        <= skip_n;
      csum_ok     <= csum_ok_n;
      to_cnt      <= to_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      out_cmd     <= cmd_n;
      frame_start <= start_n;
      frame_ok    <= ok_n;
      frame_err   <= err_n;
      err_code    <= code_n;
    end
  end

  always_comb begin
    state_n   = state;
    csum_n    = csum;
    remain_n  = remain;
    skip_n    = skip;
    csum_ok_n = csum_ok;
    data_n    = out_data;
    cmd_n     = out_cmd;
    code_n    = err_code;
    valid_n   = 1'b0;
    start_n   = 1'b0;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    to_n      = (state == IDLE || word_rdy) ? '0 : to_cnt + 1'b1;
    // A word arriving on the terminal-count cycle takes precedence over the timeout.
    if (word_rdy) begin
      case (state)
        IDLE: begin
          if (word == {BLOCK_ADDR, 8'h00}) begin
            csum_n  = word;
            start_n = 1'b1;
            state_n = SIZE;
          end else begin
            state_n = SKIP_SIZE;
          end
        end
        SIZE: begin
          remain_n = word[15:8];
          cmd_n    = word[7:0];
          csum_n   = csum + word;
          if (word[15:8] > MAX_SIZE) begin
            err_n   = 1'b1;
            code_n  = 2'd2;
            state_n = IDLE;
          end else if (word[15:8] == 8'd0) begin
            state_n = CSUM;
          end else begin
            state_n = DATA;
          end
        end
        DATA: begin
          data_n   = word;
          valid_n  = 1'b1;
          csum_n   = csum + word;
          remain_n = remain - 8'd1;
          if (remain == 8'd1) state_n = CSUM;
        end
        CSUM: begin
          csum_ok_n = (word == csum);
          state_n   = TRAIL;
        end
        TRAIL: begin
          if (csum_ok) begin
            ok_n = 1'b1;
          end else begin
            err_n  = 1'b1;
            code_n = 2'd1;
          end
          state_n = IDLE;
        end
        SKIP_SIZE: begin
          skip_n  = word[15:8] + 8'd2;
          state_n = (skip_n == 8'd0) ? IDLE : SKIP;
        end
        SKIP: begin
          skip_n = skip - 8'd1;
          if (skip == 8'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      err_n   = 1'b1;
      code_n  = 2'd3;
      state_n = IDLE;
      to_n    = '0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
